// File: rtl/signature_frame_tx_pkg.sv
// rtl/signature_frame_tx_pkg.sv - shared record, SOF constant and state types for the signature link
package sig_pkg;

    localparam logic [7:0] SIG_SOF = 8'hA5;

    typedef struct packed {
        logic [7:0] region;
        logic [7:0] auth_level;
        logic [7:0] expiry;
        logic [7:0] signature_id;
    } sig_record_t;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        REGION,
        AUTH,
        EXPIRY,
        SIGID,
`ifdef SIG_TX_CHECKSUM_EN
        CSUM,
`endif
        GAP
    } sig_tx_state_t;

endpackage

// File: rtl/signature_frame_tx_if.sv
// rtl/signature_frame_tx_if.sv - record input handshake and framed byte stream of signature_frame_tx
interface signature_frame_tx_if;
    logic       rec_valid;
    logic       rec_ready;
    logic [7:0] region;
    logic [7:0] auth_level;
    logic [7:0] expiry;
    logic [7:0] signature_id;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;

    // master is the framer: it accepts records and drives the byte stream
    modport master (
        input  rec_valid, region, auth_level, expiry, signature_id, tx_ready,
        output rec_ready, tx_valid, tx_data, tx_last
    );

    modport slave (
        output rec_valid, region, auth_level, expiry, signature_id, tx_ready,
        input  rec_ready, tx_valid, tx_data, tx_last
    );
endinterface

// File: rtl/signature_frame_tx.sv
// rtl/signature_frame_tx.sv - serializes signature records into SOF-framed bytes; SIG_TX_CHECKSUM_EN adds XOR checksum byte
module signature_frame_tx
    import sig_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE   = SIG_SOF,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    signature_frame_tx_if.master       link,
    output logic                       busy,
    output logic [15:0]                frames_sent
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam sig_tx_state_t AFTER_LAST = (GAP_CYCLES == 0) ? IDLE : GAP;

    sig_tx_state_t state;
    sig_tx_state_t state_nxt;
    sig_record_t   rec_q;
    logic [3:0]    gap_cnt;
    logic [15:0]   frame_cnt;
    logic          tx_valid_d;
    logic          tx_last_d;
    logic [7:0]    tx_byte;
    logic          final_fire;

`ifdef SIG_TX_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = SOF_BYTE ^ rec_q.region ^ rec_q.auth_level ^ rec_q.expiry ^ rec_q.signature_id;
`endif

    always_comb begin
        state_nxt  = state;
        tx_valid_d = 1'b1;
        tx_last_d  = 1'b0;
        tx_byte    = 8'h00;
        case (state)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (link.rec_valid) state_nxt = SOF;
            end
            SOF: begin
                tx_byte = SOF_BYTE;
                if (link.tx_ready) state_nxt = REGION;
            end
            REGION: begin
                tx_byte = rec_q.region;
                if (link.tx_ready) state_nxt = AUTH;
            end
            AUTH: begin
                tx_byte = rec_q.auth_level;
                if (link.tx_ready) state_nxt = EXPIRY;
            end
            EXPIRY: begin
                tx_byte = rec_q.expiry;
                if (link.tx_ready) state_nxt = SIGID;
            end
            SIGID: begin
                tx_byte = rec_q.signature_id;
`ifdef SIG_TX_CHECKSUM_EN
                if (link.tx_ready) state_nxt = CSUM;
`else
                tx_last_d = 1'b1;
                if (link.tx_ready) state_nxt = AFTER_LAST;
`endif
            end
`ifdef SIG_TX_CHECKSUM_EN
            CSUM: begin
                tx_byte   = csum;
                tx_last_d = 1'b1;
                if (link.tx_ready) state_nxt = AFTER_LAST;
            end
`endif
            GAP: begin
                tx_valid_d = 1'b0;
                if (gap_cnt == 4'd0) state_nxt = IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    assign final_fire = tx_last_d && link.tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rec_q     <= '0;
            gap_cnt   <= 4'd0;
            frame_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && link.rec_valid) begin
                rec_q <= '{region:       link.region,
                           auth_level:   link.auth_level,
                           expiry:       link.expiry,
                           signature_id: link.signature_id};
            end
            // gap counter is loaded on the last byte so GAP lasts exactly GAP_CYCLES cycles
            if (final_fire) begin
                frame_cnt <= frame_cnt + 16'd1;
                gap_cnt   <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    assign link.rec_ready = (state == IDLE);
    assign link.tx_valid  = tx_valid_d;
    assign link.tx_data   = tx_byte;
    assign link.tx_last   = tx_last_d;
    assign busy           = (state != IDLE);
    assign frames_sent    = frame_cnt;

endmodule

// File: tb/tb_signature_frame_tx.sv
// tb/tb_signature_frame_tx.sv - directed self-checking bench for signature_frame_tx
module tb_signature_frame_tx;
    import sig_pkg::*;

`ifdef SIG_TX_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif
    localparam int GAP    = 2;
    localparam int PERIOD = NBYTES + GAP + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] frames_sent;

    signature_frame_tx_if bus ();

    signature_frame_tx #(.SOF_BYTE(8'hA5), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .link        (bus),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] got_data [8];
    logic       got_last [8];
    int         got_n;
    logic [7:0] stall_data [4];
    logic       stall_valid [4];
    int         stall_n;

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 50 && busy; i++) @(negedge clk);
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s idle_timeout: busy=%b after %0d cycles, want 0", tag, busy, i);
        end
    endtask

    task automatic drive_record(input logic [7:0] r, input logic [7:0] a,
                                input logic [7:0] e, input logic [7:0] s);
        int i;
        @(negedge clk);
        bus.rec_valid    = 1'b1;
        bus.region       = r;
        bus.auth_level   = a;
        bus.expiry       = e;
        bus.signature_id = s;
        for (i = 0; i < 50 && !bus.rec_ready; i++) @(negedge clk);
        if (!bus.rec_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: rec_ready=%b, want 1", bus.rec_ready);
        end
        @(negedge clk);
        bus.rec_valid    = 1'b0;
        bus.region       = 8'h5A;
        bus.auth_level   = 8'hC3;
        bus.expiry       = 8'h99;
        bus.signature_id = 8'h66;
    endtask

    // Gathers accepted bytes until tx_last is accepted; optionally stalls 3 cycles at one byte index
    task automatic collect(input int stall_at, input bit toggle);
        bit done = 1'b0;
        bit rdy;
        int stalls = 0;
        got_n = 0;
        for (int g = 0; g < 100 && !done; g++) begin
            if (stall_at >= 0 && got_n == stall_at && bus.tx_valid && stalls < 3) begin
                rdy = 1'b0;
                stall_data[stalls]  = bus.tx_data;
                stall_valid[stalls] = bus.tx_valid;
                stalls++;
            end else if (toggle) begin
                rdy = g[0];
            end else begin
                rdy = 1'b1;
            end
            bus.tx_ready = rdy;
            if (bus.tx_valid && rdy && got_n < 8) begin
                got_data[got_n] = bus.tx_data;
                got_last[got_n] = bus.tx_last;
                got_n++;
                if (bus.tx_last) done = 1'b1;
            end
            @(negedge clk);
        end
        stall_n = stalls;
        bus.tx_ready = 1'b1;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: got %0d bytes without tx_last, want %0d", got_n, NBYTES);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.rec_valid = 1'b1;
        bus.tx_ready  = 1'b1;
        bus.region = 8'h11; bus.auth_level = 8'h22; bus.expiry = 8'h33; bus.signature_id = 8'h44;
        repeat (3) @(negedge clk);
        tests++; if (bus.rec_ready !== 1'b1) begin fails++; $display("FAIL reset rec_ready: got %b want 1", bus.rec_ready); end
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL reset tx_valid: got %b want 0", bus.tx_valid); end
        tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset tx_data: got %h want 00", bus.tx_data); end
        tests++; if (bus.tx_last !== 1'b0) begin fails++; $display("FAIL reset tx_last: got %b want 0", bus.tx_last); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL reset frames_sent: got %0d want 0", frames_sent); end
        rst = 1'b0;
        bus.rec_valid = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset ignored_record: busy=%b want 0", busy); end
    endtask

    task automatic test_basic;
`ifdef SIG_TX_CHECKSUM_EN
        logic [7:0] exp_b [6] = '{8'hA5, 8'h0A, 8'h01, 8'h10, 8'hF3, 8'h4D};
`else
        logic [7:0] exp_b [6] = '{8'hA5, 8'h0A, 8'h01, 8'h10, 8'hF3, 8'h00};
`endif
        drive_record(8'h0A, 8'h01, 8'h10, 8'hF3);
        collect(-1, 1'b0);
        tests++; if (got_n !== NBYTES) begin fails++; $display("FAIL basic byte_count: got %0d want %0d", got_n, NBYTES); end
        for (int i = 0; i < NBYTES; i++) begin
            tests++;
            if (got_data[i] !== exp_b[i] || got_last[i] !== (i == NBYTES - 1)) begin
                fails++;
                $display("FAIL basic byte%0d: got %h last=%b want %h last=%b", i, got_data[i], got_last[i], exp_b[i], (i == NBYTES - 1));
            end
        end
        tests++; if (frames_sent !== 16'd1) begin fails++; $display("FAIL basic frames_sent: got %0d want 1", frames_sent); end
        tests++;
        if (bus.rec_ready !== 1'b0 || bus.tx_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic gap: rec_ready=%b tx_valid=%b busy=%b want 0 0 1", bus.rec_ready, bus.tx_valid, busy);
        end
        wait_idle("basic");
    endtask

    task automatic test_backpressure;
`ifdef SIG_TX_CHECKSUM_EN
        logic [7:0] exp_b [6] = '{8'hA5, 8'h0A, 8'h01, 8'h10, 8'hF3, 8'h4D};
`else
        logic [7:0] exp_b [6] = '{8'hA5, 8'h0A, 8'h01, 8'h10, 8'hF3, 8'h00};
`endif
        drive_record(8'h0A, 8'h01, 8'h10, 8'hF3);
        collect(2, 1'b0);
        tests++; if (stall_n !== 3) begin fails++; $display("FAIL bp stall_count: got %0d want 3", stall_n); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (stall_data[i] !== 8'h01 || stall_valid[i] !== 1'b1) begin
                fails++;
                $display("FAIL bp hold%0d: got %h valid=%b want 01 valid=1", i, stall_data[i], stall_valid[i]);
            end
        end
        tests++; if (got_n !== NBYTES) begin fails++; $display("FAIL bp byte_count: got %0d want %0d", got_n, NBYTES); end
        for (int i = 0; i < NBYTES; i++) begin
            tests++;
            if (got_data[i] !== exp_b[i] || got_last[i] !== (i == NBYTES - 1)) begin
                fails++;
                $display("FAIL bp byte%0d: got %h last=%b want %h", i, got_data[i], got_last[i], exp_b[i]);
            end
        end
        tests++; if (frames_sent !== 16'd2) begin fails++; $display("FAIL bp frames_sent: got %0d want 2", frames_sent); end
        wait_idle("bp");
    endtask

    task automatic test_back_to_back;
        int sof_cyc [2];
        int nsof = 0;
        int viol = 0;
        @(negedge clk);
        bus.tx_ready = 1'b1;
        bus.rec_valid = 1'b1;
        bus.region = 8'h11; bus.auth_level = 8'h22; bus.expiry = 8'h33; bus.signature_id = 8'h44;
        for (int i = 0; i < 60 && nsof < 2; i++) begin
            @(negedge clk);
            if (bus.tx_valid && bus.tx_data == 8'hA5) begin
                sof_cyc[nsof] = i;
                nsof++;
            end
            if (bus.rec_ready === busy) viol++;
        end
        bus.rec_valid = 1'b0;
        wait_idle("b2b");
        tests++; if (nsof !== 2) begin fails++; $display("FAIL b2b sof_count: got %0d want 2", nsof); end
        tests++;
        if (nsof == 2 && sof_cyc[1] - sof_cyc[0] !== PERIOD) begin
            fails++;
            $display("FAIL b2b sof_spacing: got %0d want %0d", sof_cyc[1] - sof_cyc[0], PERIOD);
        end
        tests++; if (viol !== 0) begin fails++; $display("FAIL b2b rec_ready_vs_busy: got %0d bad cycles want 0", viol); end
        tests++; if (frames_sent !== 16'd4) begin fails++; $display("FAIL b2b frames_sent: got %0d want 4", frames_sent); end
    endtask

    task automatic test_reset_mid_frame;
`ifdef SIG_TX_CHECKSUM_EN
        logic [7:0] exp_b [6] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
`else
        logic [7:0] exp_b [6] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        drive_record(8'h0A, 8'h01, 8'h10, 8'hF3);
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bus.tx_data !== 8'h10 || bus.tx_valid !== 1'b1) begin fails++; $display("FAIL rstmid expiry: got %h valid=%b want 10 valid=1", bus.tx_data, bus.tx_valid); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rstmid tx_valid: got %b want 0", bus.tx_valid); end
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL rstmid frames_sent: got %0d want 0", frames_sent); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rstmid no_resume: busy=%b tx_valid=%b want 0 0", busy, bus.tx_valid); end
        drive_record(8'h00, 8'h00, 8'h00, 8'h00);
        collect(-1, 1'b0);
        tests++; if (got_n !== NBYTES) begin fails++; $display("FAIL rstmid byte_count: got %0d want %0d", got_n, NBYTES); end
        for (int i = 0; i < NBYTES; i++) begin
            tests++;
            if (got_data[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL rstmid byte%0d: got %h want %h", i, got_data[i], exp_b[i]);
            end
        end
        tests++; if (frames_sent !== 16'd1) begin fails++; $display("FAIL rstmid frames_after: got %0d want 1", frames_sent); end
        wait_idle("rstmid");
    endtask

    task automatic test_toggle_ready;
`ifdef SIG_TX_CHECKSUM_EN
        logic [7:0] exp_b [6] = '{8'hA5, 8'h3C, 8'h07, 8'hE1, 8'h42, 8'h3D};
`else
        logic [7:0] exp_b [6] = '{8'hA5, 8'h3C, 8'h07, 8'hE1, 8'h42, 8'h00};
`endif
        drive_record(8'h3C, 8'h07, 8'hE1, 8'h42);
        collect(-1, 1'b1);
        tests++; if (got_n !== NBYTES) begin fails++; $display("FAIL toggle byte_count: got %0d want %0d", got_n, NBYTES); end
        for (int i = 0; i < NBYTES; i++) begin
            tests++;
            if (got_data[i] !== exp_b[i] || got_last[i] !== (i == NBYTES - 1)) begin
                fails++;
                $display("FAIL toggle byte%0d: got %h last=%b want %h", i, got_data[i], got_last[i], exp_b[i]);
            end
        end
        tests++; if (frames_sent !== 16'd2) begin fails++; $display("FAIL toggle frames_sent: got %0d want 2", frames_sent); end
        wait_idle("toggle");
    endtask

    task automatic test_counter_wrap;
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        drive_record(8'h01, 8'h02, 8'h03, 8'h04);
        collect(-1, 1'b0);
        tests++; if (frames_sent !== 16'h0000) begin fails++; $display("FAIL wrap frames_sent: got %h want 0000", frames_sent); end
        wait_idle("wrap");
    endtask

    initial begin
        bus.tx_ready = 1'b1;
        bus.rec_valid = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_frame;
        test_toggle_ready;
        test_counter_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
